// File: rtl/alu_seq_ctrl.sv
// Multi-cycle execution controller for a WIDTH-bit integer ALU: single-cycle ops, iterative mul/div.
// Optional build macro ALU_SEQ_FAST_MUL_EN selects a combinational multiplier with latency 1.
module alu_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] rsp_hi,
    output logic             rsp_o,
    output logic             rsp_n,
    output logic             rsp_z,
    output logic             rsp_err,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'b1111;
    localparam logic [3:0] OP_SUB = 4'b1110;
    localparam logic [3:0] OP_AND = 4'b1101;
    localparam logic [3:0] OP_OR  = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b0001;
    localparam logic [3:0] OP_DIV = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b1010;
    localparam logic [3:0] OP_SRL = 4'b1011;
    localparam logic [3:0] OP_ROL = 4'b1000;
    localparam logic [3:0] OP_ROR = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r, b_r, acc_r, lo_r;
    logic [SHW-1:0]   cnt_r;
    logic             req_ready_r, busy_r, rsp_valid_r;
    logic [WIDTH-1:0] rsp_result_r, rsp_hi_r;
    logic             rsp_o_r, rsp_n_r, rsp_z_r, rsp_err_r;

    assign req_ready  = req_ready_r;
    assign busy       = busy_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;
    assign rsp_hi     = rsp_hi_r;
    assign rsp_o      = rsp_o_r;
    assign rsp_n      = rsp_n_r;
    assign rsp_z      = rsp_z_r;
    assign rsp_err    = rsp_err_r;

    // Single-cycle datapath operands
    logic [WIDTH-1:0]   sum_s, neg_b_s, diff_s;
    logic [2*WIDTH-1:0] rot_l_s, rot_r_s;
    logic [SHW-1:0]     shamt_s;
    logic               big_shift_s;
    logic [WIDTH-1:0]   sc_result_s, sc_hi_s;
    logic               sc_o_s, sc_err_s;
    logic               is_iter_mul_s;

    assign sum_s       = req_a + req_b;
    assign neg_b_s     = ~req_b + WIDTH'(1);
    assign diff_s      = req_a + neg_b_s;
    assign shamt_s     = req_b[SHW-1:0];
    assign big_shift_s = |req_b[WIDTH-1:SHW];
    assign rot_l_s     = {req_a, req_a} << shamt_s;
    assign rot_r_s     = {req_a, req_a} >> shamt_s;

`ifdef ALU_SEQ_FAST_MUL_EN
    logic [2*WIDTH-1:0] prod_s;
    assign prod_s        = {{WIDTH{1'b0}}, req_a} * {{WIDTH{1'b0}}, req_b};
    assign is_iter_mul_s = 1'b0;
`else
    assign is_iter_mul_s = (req_op == OP_MUL);
`endif

    // Response of every op that completes in the accepting cycle
    always_comb begin
        sc_result_s = '0;
        sc_hi_s     = '0;
        sc_o_s      = 1'b0;
        sc_err_s    = 1'b0;
        case (req_op)
            OP_ADD: begin
                sc_result_s = sum_s;
                sc_o_s      = (req_a[WIDTH-1] == req_b[WIDTH-1]) && (sum_s[WIDTH-1] != req_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result_s = diff_s;
                sc_o_s      = (req_a[WIDTH-1] == neg_b_s[WIDTH-1]) && (diff_s[WIDTH-1] != req_a[WIDTH-1]);
            end
            OP_AND: sc_result_s = req_a & req_b;
            OP_OR:  sc_result_s = req_a | req_b;
            OP_SLL: sc_result_s = big_shift_s ? '0 : (req_a << shamt_s);
            OP_SRL: sc_result_s = big_shift_s ? '0 : (req_a >> shamt_s);
            OP_ROL: sc_result_s = rot_l_s[2*WIDTH-1:WIDTH];
            OP_ROR: sc_result_s = rot_r_s[WIDTH-1:0];
`ifdef ALU_SEQ_FAST_MUL_EN
            OP_MUL: begin
                sc_result_s = prod_s[WIDTH-1:0];
                sc_hi_s     = prod_s[2*WIDTH-1:WIDTH];
                sc_o_s      = |prod_s[2*WIDTH-1:WIDTH];
            end
`else
            OP_MUL: sc_result_s = '0;
`endif
            // Only divide-by-zero reaches this path; nonzero divisors go iterative
            OP_DIV: begin
                sc_result_s = (req_b == '0) ? {WIDTH{1'b1}} : '0;
                sc_hi_s     = (req_b == '0) ? req_a : '0;
                sc_err_s    = (req_b == '0);
            end
            default: sc_err_s = 1'b1;
        endcase
    end

    // One shift-add step: acc_r holds the running high half, lo_r the multiplier/low half
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] mul_hi_nx_s, mul_lo_nx_s;
    assign mul_sum_s   = {1'b0, acc_r} + (lo_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    assign mul_hi_nx_s = mul_sum_s[WIDTH:1];
    assign mul_lo_nx_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};

    // One restoring-division step: acc_r is the partial remainder, lo_r shifts dividend out / quotient in
    logic [WIDTH:0]   div_shift_s, div_trial_s;
    logic [WIDTH-1:0] div_rem_nx_s, div_quo_nx_s;
    assign div_shift_s  = {acc_r, lo_r[WIDTH-1]};
    assign div_trial_s  = div_shift_s - {1'b0, b_r};
    assign div_rem_nx_s = div_trial_s[WIDTH] ? div_shift_s[WIDTH-1:0] : div_trial_s[WIDTH-1:0];
    assign div_quo_nx_s = {lo_r[WIDTH-2:0], ~div_trial_s[WIDTH]};

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            a_r          <= '0;
            b_r          <= '0;
            acc_r        <= '0;
            lo_r         <= '0;
            cnt_r        <= '0;
            req_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= '0;
            rsp_hi_r     <= '0;
            rsp_o_r      <= 1'b0;
            rsp_n_r      <= 1'b0;
            rsp_z_r      <= 1'b0;
            rsp_err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        a_r         <= req_a;
                        b_r         <= req_b;
                        cnt_r       <= '0;
                        acc_r       <= '0;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (is_iter_mul_s) begin
                            lo_r    <= req_b;
                            state_r <= ST_MUL;
                        end else if ((req_op == OP_DIV) && (req_b != '0)) begin
                            lo_r    <= req_a;
                            state_r <= ST_DIV;
                        end else begin
                            rsp_result_r <= sc_result_s;
                            rsp_hi_r     <= sc_hi_s;
                            rsp_o_r      <= sc_o_s;
                            rsp_n_r      <= sc_result_s[WIDTH-1];
                            rsp_z_r      <= (sc_result_s == '0);
                            rsp_err_r    <= sc_err_s;
                            rsp_valid_r  <= 1'b1;
                            state_r      <= ST_RESP;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    acc_r <= mul_hi_nx_s;
                    lo_r  <= mul_lo_nx_s;
                    cnt_r <= cnt_r + SHW'(1);
                    if (cnt_r == CNT_LAST) begin
                        rsp_result_r <= mul_lo_nx_s;
                        rsp_hi_r     <= mul_hi_nx_s;
                        rsp_o_r      <= |mul_hi_nx_s;
                        rsp_n_r      <= mul_lo_nx_s[WIDTH-1];
                        rsp_z_r      <= (mul_lo_nx_s == '0);
                        rsp_err_r    <= 1'b0;
                        rsp_valid_r  <= 1'b1;
                        state_r      <= ST_RESP;
                    end else begin
                        state_r <= ST_MUL;
                    end
                end
                ST_DIV: begin
                    acc_r <= div_rem_nx_s;
                    lo_r  <= div_quo_nx_s;
                    cnt_r <= cnt_r + SHW'(1);
                    if (cnt_r == CNT_LAST) begin
                        rsp_result_r <= div_quo_nx_s;
                        rsp_hi_r     <= div_rem_nx_s;
                        rsp_o_r      <= 1'b0;
                        rsp_n_r      <= div_quo_nx_s[WIDTH-1];
                        rsp_z_r      <= (div_quo_nx_s == '0);
                        rsp_err_r    <= 1'b0;
                        rsp_valid_r  <= 1'b1;
                        state_r      <= ST_RESP;
                    end else begin
                        state_r <= ST_DIV;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: directed vectors, monitor checks every presented response.
module tb_alu_seq_ctrl;
    localparam logic [3:0] OP_ADD = 4'b1111;
    localparam logic [3:0] OP_SUB = 4'b1110;
    localparam logic [3:0] OP_AND = 4'b1101;
    localparam logic [3:0] OP_OR  = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b0001;
    localparam logic [3:0] OP_DIV = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b1010;
    localparam logic [3:0] OP_SRL = 4'b1011;
    localparam logic [3:0] OP_ROL = 4'b1000;
    localparam logic [3:0] OP_ROR = 4'b1001;
`ifdef ALU_SEQ_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 17;
`endif
    localparam int DIV_LAT = 17;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'b0000;
    logic [15:0] req_a = 16'h0000;
    logic [15:0] req_b = 16'h0000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_result, rsp_hi;
    logic        rsp_o, rsp_n, rsp_z, rsp_err, busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic [15:0] hi;
        logic        o, n, z, err;
        int          lat;
        int          acc_cyc;
    } exp_t;
    exp_t sb_q[$];

    alu_seq_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_hi(rsp_hi),
        .rsp_o(rsp_o), .rsp_n(rsp_n), .rsp_z(rsp_z), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation when a response first appears, re-checks it every cycle it is held
    exp_t cur;
    bit   seen = 1'b0;
    bit   have_cur = 1'b0;
    always @(negedge clk) begin
        if (!rst_n || !rsp_valid) begin
            seen = 1'b0;
        end else begin
            if (!seen) begin
                seen = 1'b1;
                checks++;
                if (sb_q.size() == 0) begin
                    have_cur = 1'b0;
                    failures++;
                    $display("FAIL unexpected_response: got result %h with empty scoreboard", rsp_result);
                end else begin
                    cur = sb_q.pop_front();
                    have_cur = 1'b1;
                    if (cyc - cur.acc_cyc != cur.lat) begin
                        failures++;
                        $display("FAIL %s_latency: got %0d expected %0d", cur.name, cyc - cur.acc_cyc, cur.lat);
                    end
                end
            end
            if (have_cur) begin
                chk({cur.name, "_result"}, {16'h0, rsp_result}, {16'h0, cur.res});
                chk({cur.name, "_hi"}, {16'h0, rsp_hi}, {16'h0, cur.hi});
                chk({cur.name, "_flags_onze"}, {28'h0, rsp_o, rsp_n, rsp_z, rsp_err},
                    {28'h0, cur.o, cur.n, cur.z, cur.err});
            end
        end
    end

    task automatic issue(input string nm, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input logic [15:0] eh,
                         input logic eo, input logic en, input logic ez, input logic ee,
                         input int lat, input bit push);
        exp_t e;
        int waited = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept_timeout: req_ready stayed 0 for %0d cycles", nm, waited);
            req_valid = 1'b0;
            return;
        end
        e.name = nm; e.res = er; e.hi = eh;
        e.o = eo; e.n = en; e.z = ez; e.err = ee;
        e.lat = lat; e.acc_cyc = cyc;
        if (push) sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int waited = 0;
        while ((sb_q.size() != 0 || rsp_valid) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() != 0 || rsp_valid) begin
            checks++;
            failures++;
            $display("FAIL %s_drain_timeout: %0d responses outstanding", nm, sb_q.size());
        end
    endtask

    initial begin
        #1;
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_result", {16'h0, rsp_result}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", {31'h0, req_ready}, 32'h1);

        //    name          op      A         B         result    hi        o     n     z     err   latency
        issue("add_ovf",   OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        issue("add_wrap",  OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1);
        issue("sub_zero",  OP_SUB, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1);
        issue("sub_ovf",   OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        issue("and",       OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        issue("or",        OP_OR,  16'hF000, 16'h000F, 16'hF00F, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        issue("mul_big",   OP_MUL, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b1, 1'b0, 1'b0, 1'b0, MUL_LAT, 1'b1);
        issue("mul_small", OP_MUL, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, MUL_LAT, 1'b1);
        issue("mul_max",   OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0, MUL_LAT, 1'b1);
        issue("div_100_7", OP_DIV, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 1'b0, 1'b0, DIV_LAT, 1'b1);
        issue("div_by_1",  OP_DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, DIV_LAT, 1'b1);
        issue("div_zero",  OP_DIV, 16'h0042, 16'h0000, 16'hFFFF, 16'h0042, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1);
        issue("rol",       OP_ROL, 16'h8001, 16'h0004, 16'h0018, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        issue("ror",       OP_ROR, 16'h0001, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        issue("rol_hi_b",  OP_ROL, 16'h00F0, 16'hFFF4, 16'h0F00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        issue("sll_big",   OP_SLL, 16'h0001, 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1);
        issue("srl_15",    OP_SRL, 16'h8000, 16'h000F, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        issue("illegal",   4'b0000, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        drain("main");

        // Back-pressure: response must be held while rsp_ready is low
        rsp_ready = 1'b0;
        issue("sub_hold",  OP_SUB, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
            chk("hold_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        drain("hold");

        // Reset in the middle of a division: no response may ever appear for it
        issue("div_rst",   OP_DIV, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 1'b0, 1'b0, DIV_LAT, 1'b0);
        repeat (7) @(negedge clk);
        chk("middiv_busy", {31'h0, busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_result_cleared", {16'h0, rsp_result}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
        repeat (25) @(negedge clk);
        chk("post_rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
        issue("add_after", OP_ADD, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        drain("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle execution controller for the 16-bit integer ALU of the CPE142 datapath.
- Accepts one operation at a time over a valid/ready request channel.
- Single-cycle ops (add, sub, and, or, shifts, rotates) complete directly; mul and div are sequenced iteratively.
- Returns result plus O/N/Z flags and an error flag over a valid/ready response channel to the decode/writeback stage.

Parameters:
- WIDTH, 16, operand/result width. Iteration count = WIDTH; shift amount uses the low log2(WIDTH) bits of B.

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_op  in  4  opcode: 1111 add, 1110 sub, 1101 and, 1100 or, 0001 mul, 0010 div, 1010 sll, 1011 srl, 1000 rol, 1001 ror; all others illegal
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- rsp_valid  out  1  response held stable until accepted
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  WIDTH  result, mul low half, or div quotient
- rsp_hi  out  WIDTH  mul high half, div remainder, else 0
- rsp_o  out  1  overflow flag
- rsp_n  out  1  negative flag
- rsp_z  out  1  zero flag
- rsp_err  out  1  illegal opcode or divide by zero
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All rsp_* outputs and busy are 0; req_ready is 1 once rst_n is released.
  - Iteration counter and internal operand registers are cleared.
  - Reset mid-operation discards the in-flight op; no response is produced.
- States: IDLE, MUL, DIV, RESP.
- IDLE:
  - On req_valid&req_ready, latch op, A and B.
  - Single-cycle op, illegal op, or div with B==0: compute and register the response, go to RESP. rsp_valid is high on the cycle after acceptance (latency 1).
  - mul: go to MUL. div with B!=0: go to DIV.
- MUL: unsigned shift-add, one multiplier bit per cycle, WIDTH cycles, then RESP. rsp_valid rises WIDTH+1 cycles after acceptance.
- DIV: unsigned restoring division, one quotient bit per cycle, WIDTH cycles, then RESP. Same latency as MUL.
- RESP: hold all rsp_* stable while rsp_ready=0. On rsp_valid&rsp_ready, go to IDLE and drop rsp_valid next cycle. Minimum spacing between requests is 2 cycles.
- req_ready=0 in MUL, DIV and RESP; request inputs are ignored there.
- Arithmetic (all modulo 2^WIDTH):
  - add: R=A+B.
  - sub: R=A+(~B+1).
  - add/sub rsp_o: signed overflow, i.e. operand signs equal (A and B for add; A and ~B+1 for sub) and result sign differs.
  - mul: rsp_o=(hi!=0).
  - All other ops: rsp_o=0.
- Shifts and rotates:
  - sll/srl: logical shift by B[3:0]; if any of B[WIDTH-1:4] is set, result=0.
  - rol/ror: rotate by B[3:0]; upper bits of B ignored.
- Flags: rsp_z=(rsp_result==0) and rsp_n=rsp_result[WIDTH-1] for every op, including mul/div low/quotient.
- Divide by zero: rsp_result=all ones, rsp_hi=A, rsp_err=1, rsp_o=0.
- Illegal opcode: rsp_result=0, rsp_hi=0, rsp_err=1, rsp_z=1, rsp_n=0, rsp_o=0.
- Simultaneous events: a req_valid arriving in the same cycle a response is accepted is not taken; it must be held until IDLE asserts req_ready.

Optional Feature:
- Macro: ALU_SEQ_FAST_MUL_EN.
- Defined: mul uses a combinational WIDTHxWIDTH multiplier and completes with latency 1, like the other single-cycle ops. The MUL state is never entered.
- Undefined: mul is iterative as described above, with latency WIDTH+1.
- Result, hi and flags are identical in both builds.

Test Plan:
- Add overflow: add A=16'h7FFF, B=16'h0001 -> 1 cycle later rsp_result=16'h8000, rsp_o=1, rsp_n=1, rsp_z=0, rsp_err=0.
- Sub to zero: sub A=16'h1234, B=16'h1234 -> rsp_result=0, rsp_z=1, rsp_o=0. Repeat with rsp_ready held low 5 cycles -> outputs stable, req_ready=0 throughout.
- Mul: mul A=16'h1234, B=16'h0100 -> rsp_valid exactly 17 cycles after accept (1 with ALU_SEQ_FAST_MUL_EN), rsp_result=16'h3400, rsp_hi=16'h0012, rsp_o=1. Then mul 3x5 -> result 15, hi 0, rsp_o=0.
- Div: div A=16'd100, B=16'd7 -> rsp_result=14, rsp_hi=2, latency 17. div A=16'h0042, B=0 -> latency 1, rsp_result=16'hFFFF, rsp_hi=16'h0042, rsp_err=1.
- Shifts/rotates/illegal:
  - rol A=16'h8001, B=4 -> 16'h0018.
  - ror A=16'h0001, B=1 -> 16'h8000, rsp_n=1.
  - sll A=16'h0001, B=16'h0010 -> 0, rsp_z=1.
  - op 4'b0000 -> rsp_err=1, result 0.
- Reset mid-div: assert rst_n=0 at iteration 8 -> rsp_valid and busy go 0 immediately, req_ready=1 after release, and no stale response is ever presented.
